// File: rtl/mem_stream_pkg.sv
// Shared types and sizing helpers for the port-B streaming reader.
// Optional feature macro: MEM_STREAM_READER_LOOP_EN.
package mem_stream_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with show-ahead head output.
// Power-of-2 depth; async active-low reset clears storage.
module stream_fifo
  import mem_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign pop_ok  = pop && (cnt_q != '0);
  assign push_ok = push && ((cnt_q != FULL_C) || pop_ok);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign pop_data = mem_q[rd_q];
  assign full     = (cnt_q == FULL_C);
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;

endmodule

// File: rtl/mem_stream_reader.sv
// Streams `length` words from memory port B onto a valid/ready output.
// MEM_STREAM_READER_LOOP_EN adds a `loop` input for repeated passes.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
`ifdef MEM_STREAM_READER_LOOP_EN
  input  logic              loop,
`endif
  output logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = cnt_w(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [ADDR_W:0]  LEN1_C  = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occ;
  logic              fifo_full, fifo_empty;
  logic              accept, issue, last_rd, wrap_rd;
  logic              pop, last_pop, pass_done;

  assign accept = (state_q == IDLE) && start;
  assign pop    = out_valid && out_ready;

  // Reserve a slot for the word still in flight so the FIFO never overflows.
  assign occ     = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign issue   = (state_q == READ) && (rem_q != '0) && !fifo_full
                && (occ < DEPTH_C);
  assign last_rd = issue && (rem_q == LEN1_C);

  assign last_pop = pop && !inflight_q && (fifo_count == ONE_C);

`ifdef MEM_STREAM_READER_LOOP_EN
  logic              loop_q, loop_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   pcnt_q, pcnt_d;
  logic              pass_q, pass_d;

  assign wrap_rd   = last_rd && loop_q && loop;
  assign pass_done = pass_q;

  // Accepted-word count within a pass drives the per-pass done pulse.
  always_comb begin
    loop_d = loop_q;
    base_d = base_q;
    len_d  = len_q;
    pcnt_d = pcnt_q;
    pass_d = pop && (pcnt_q == len_q - 1'b1);
    if (accept) begin
      loop_d = loop;
      base_d = base_addr;
      len_d  = length;
      pcnt_d = '0;
    end else if (pop) begin
      pcnt_d = pass_d ? '0 : pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loop_q <= 1'b0;
      base_q <= '0;
      len_q  <= '0;
      pcnt_q <= '0;
      pass_q <= 1'b0;
    end else begin
      loop_q <= loop_d;
      base_q <= base_d;
      len_q  <= len_d;
      pcnt_q <= pcnt_d;
      pass_q <= pass_d;
    end
  end
`else
  assign wrap_rd   = 1'b0;
  assign pass_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = (length == '0) ? DONE : READ;
      READ:  if (last_rd && !wrap_rd) state_d = DRAIN;
      DRAIN: if (last_pop) state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    rem_d      = rem_q;
    inflight_d = issue;
    if (accept && (length != '0)) begin
      addr_d = base_addr;
      rem_d  = length;
    end else if (issue) begin
      addr_d = addr_q + 1'b1;
      rem_d  = rem_q - 1'b1;
`ifdef MEM_STREAM_READER_LOOP_EN
      if (wrap_rd) begin
        addr_d = base_q;
        rem_d  = len_q;
      end
`endif
    end
  end

  always_comb begin
    busy = (state_q == READ) || (state_q == DRAIN);
    done = (state_q == DONE) || pass_done;
  end

  assign addr_b    = addr_q;
  assign out_valid = !fifo_empty;

  stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (data_b),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomized bench for mem_stream_reader against a queue-based stream model.
// Loop scenario compiled in when MEM_STREAM_READER_LOOP_EN is defined.
module tb_mem_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic [9:0]  addr_b;
  logic [15:0] data_b;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
`ifdef MEM_STREAM_READER_LOOP_EN
  logic        loop;
  bit          loop_mode = 1'b0;
  int          loop_base = 0;
  int          loop_len  = 1;
`endif

  logic [15:0] mem [1024];
  logic [15:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int words_acc = 0;
  bit prev_stall = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) data_b <= mem[addr_b];

  mem_stream_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
`ifdef MEM_STREAM_READER_LOOP_EN
    .loop      (loop),
`endif
    .addr_b    (addr_b),
    .data_b    (data_b),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

`ifdef MEM_STREAM_READER_LOOP_EN
  function automatic logic [15:0] loop_word(input int k);
    return mem[(loop_base + (k % loop_len)) % 1024];
  endfunction
`endif

  // Stream monitor: one check per meaningful output cycle.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold_valid", out_valid, 1);
      if (done) begin
        done_seen++;
`ifdef MEM_STREAM_READER_LOOP_EN
        if (loop_mode) chk("loop_done_align", words_acc % loop_len, 0);
        else chk("busy_at_done", busy, 0);
`else
        chk("busy_at_done", busy, 0);
`endif
      end
      if (out_valid) begin
`ifdef MEM_STREAM_READER_LOOP_EN
        if (loop_mode) chk("loop_data", out_data, loop_word(words_acc));
        else
`endif
        if (exp_q.size() == 0) chk("spurious_valid", out_valid, 0);
        else chk("stream_data", out_data, exp_q[0]);
        if (out_ready) begin
          words_acc++;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input int base, input int len);
    base_addr = 10'(base);
    length    = 11'(len);
    start     = 1'b1;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % 1024]);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget,
                           input bit rnd, output int n);
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    chk(nm, done, 1);
  endtask

  int n;
  int d0;
  int a0;
  int len;
  int base;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hA000 + 16'(i);
    reset = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    out_ready = 1'b1;
`ifdef MEM_STREAM_READER_LOOP_EN
    loop = 1'b0;
`endif
    #12;
    chk("rst_addr_b", addr_b, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(2);

    // Basic 4-word transfer, first word two cycles after start.
    d0 = done_seen;
    go(5, 4);
    chk("t1_addr_after_start", addr_b, 10'd5);
    chk("t1_busy", busy, 1);
    cyc(1);
    chk("t1_no_valid_yet", out_valid, 0);
    cyc(1);
    chk("t1_first_valid", out_valid, 1);
    chk("t1_first_word", out_data, 16'hA005);
    wait_done("t1_done_seen", 50, 1'b0, n);
    chk("t1_done_latency", n, 4);
    cyc(1);
    chk("t1_busy_after", busy, 0);
    chk("t1_done_once", done_seen - d0, 1);
    chk("t1_all_words", exp_q.size(), 0);

    // Backpressure: buffer fills to depth, reads stall.
    d0 = done_seen;
    out_ready = 1'b0;
    go(0, 8);
    cyc(10);
    chk("t2_addr_stall", addr_b, 10'd4);
    chk("t2_valid_held", out_valid, 1);
    chk("t2_head_word", out_data, 16'hA000);
    out_ready = 1'b1;
    wait_done("t2_done_seen", 100, 1'b0, n);
    cyc(1);
    chk("t2_all_words", exp_q.size(), 0);
    chk("t2_done_once", done_seen - d0, 1);

    // Address wrap at the top of memory.
    go(10'h3FE, 4);
    chk("t3_model_first", exp_q[0], 16'hA3FE);
    chk("t3_model_wrap", exp_q[2], 16'hA000);
    wait_done("t3_done_seen", 50, 1'b0, n);
    cyc(1);
    chk("t3_all_words", exp_q.size(), 0);

    // Empty transfer.
    d0 = done_seen;
    go(100, 0);
    chk("t4_done_now", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_addr_unchanged", addr_b, 10'h002);
    cyc(1);
    chk("t4_done_pulse_end", done, 0);
    cyc(3);
    chk("t4_done_once", done_seen - d0, 1);

    // Abort by reset mid-transfer.
    a0 = words_acc;
    go(20, 16);
    n = 0;
    while ((words_acc - a0) < 3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t5_three_words", (words_acc - a0) >= 3, 1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    d0 = done_seen;
    chk("t5_valid_cleared", out_valid, 0);
    chk("t5_busy_cleared", busy, 0);
    exp_q.delete();
    cyc(3);
    reset = 1'b1;
    cyc(2);
    chk("t5_no_done", done_seen - d0, 0);
    chk("t5_addr_reset", addr_b, 0);
    go(40, 5);
    wait_done("t5_restart_done", 60, 1'b0, n);
    cyc(1);
    chk("t5_restart_words", exp_q.size(), 0);

    // Randomized transfers with random backpressure.
    for (int t = 0; t < 16; t++) begin
      base = $urandom_range(0, 1023);
      len  = $urandom_range(0, 12);
      d0 = done_seen;
      go(base, len);
      wait_done("rand_done_seen", 400, 1'b1, n);
      cyc(1);
      out_ready = 1'b1;
      chk("rand_all_words", exp_q.size(), 0);
      chk("rand_done_once", done_seen - d0, 1);
    end

`ifdef MEM_STREAM_READER_LOOP_EN
    // Looping passes, then stop at a pass boundary.
    loop_base = 2;
    loop_len  = 3;
    chk("loop_model_pin", loop_word(3), 16'hA002);
    out_ready = 1'b1;
    words_acc = 0;
    d0 = done_seen;
    loop_mode = 1'b1;
    loop = 1'b1;
    go(2, 3);
    exp_q.delete();
    cyc(14);
    chk("loop_progress", words_acc >= 9, 1);
    chk("loop_busy", busy, 1);
    loop = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("loop_stopped", busy, 0);
    cyc(2);
    chk("loop_whole_passes", words_acc % 3, 0);
    chk("loop_done_per_pass", done_seen - d0, words_acc / 3);
    loop_mode = 1'b0;
`endif

    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
